// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub accumulating sequencer.
//   state_t : sequencer FSM states (IDLE, DRIVE, CAPTURE)
//   OP_ADD  : add_mode value selecting acc + op_b
//   OP_SUB  : add_mode value selecting acc - op_b
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_acc_clamp.sv
// Next-accumulator select for the add/sub sequencer.
// Combinational: takes the external adder's sum/carry and the latched mode and
// produces the value written into the accumulator on the CAPTURE edge.
// Build option: ADDSUB_ACC_SAT_EN
//   defined   : add with carry clamps to all ones, sub with borrow clamps to zero
//   undefined : passthrough of the adder sum (modulo wrap)
// Ports:
//   i_sum      in   WIDTH  adder sum
//   i_cout     in   1      adder carry-out (sub: 1 = no borrow)
//   i_mode     in   1      OP_ADD / OP_SUB
//   o_acc_next out  WIDTH  value to load into the accumulator
module addsub_acc_clamp
    import addsub_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_acc_next
);

`ifdef ADDSUB_ACC_SAT_EN
    always_comb begin
        o_acc_next = i_sum;
        if ((i_mode == OP_ADD) && i_cout) begin
            o_acc_next = '1;
        end else if ((i_mode == OP_SUB) && !i_cout) begin
            o_acc_next = '0;
        end
    end
`else
    // Carry and mode only matter when saturating.
    logic w_unused;
    assign w_unused   = i_cout ^ i_mode;
    assign o_acc_next = i_sum;
`endif

endmodule

// File: rtl/addsub_acc_sequencer.sv
// Feedback/sequencing stage around an external combinational add/sub unit.
// Accepts one op per valid/ready handshake, feeds the running accumulator back as
// operand A, holds the adder inputs for a settle cycle, then captures sum and
// carry/borrow into the accumulator.
// Build option: ADDSUB_ACC_SAT_EN (saturating accumulator, see addsub_acc_clamp).
//
// state   | meaning
// IDLE    | waiting for an op; clear is honoured here
// DRIVE   | adder inputs held for one settle cycle
// CAPTURE | sum/flag registered into acc on this edge
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_valid/op_ready   op handshake; op_sub/op_b carry the op
//   clear               zero acc and cb_flag while idle
//   add_a/add_b/add_mode  drive the external adder
//   add_sum/add_cout    adder results
//   acc/acc_valid       running result and its 1-cycle update strobe
//   cb_flag             add: carry, sub: borrow
//   op_count            accepted ops since reset, saturating
module addsub_acc_sequencer
    import addsub_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] op_b,
    input  logic             clear,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_mode,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] acc,
    output logic             acc_valid,
    output logic             cb_flag,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_mode;
    logic             r_acc_valid;
    logic             r_cb_flag;
    logic [CNT_W-1:0] r_op_count;
    logic [WIDTH-1:0] w_acc_next;

    addsub_acc_clamp #(
        .WIDTH (WIDTH)
    ) u_clamp (
        .i_sum      (add_sum),
        .i_cout     (add_cout),
        .i_mode     (r_add_mode),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_add_b     <= '0;
            r_add_mode  <= OP_ADD;
            r_acc_valid <= 1'b0;
            r_cb_flag   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_acc_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // clear wins over a pending op in the same cycle
                    if (clear) begin
                        r_acc     <= '0;
                        r_cb_flag <= 1'b0;
                    end else if (op_valid) begin
                        r_add_b    <= op_b;
                        r_add_mode <= op_sub;
                        if (r_op_count != '1) begin
                            r_op_count <= r_op_count + 1'b1;
                        end
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_acc       <= w_acc_next;
                    // subtract reports borrow, which is the inverted carry
                    r_cb_flag   <= (r_add_mode == OP_SUB) ? ~add_cout : add_cout;
                    r_acc_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign op_ready  = (r_state == IDLE) && !clear;
    assign add_a     = r_acc;
    assign add_b     = r_add_b;
    assign add_mode  = r_add_mode;
    assign acc       = r_acc;
    assign acc_valid = r_acc_valid;
    assign cb_flag   = r_cb_flag;
    assign op_count  = r_op_count;

endmodule
